// File: rtl/id_ex_stage_pkg.sv
// Shared widths, writeback-select encodings and the EX register layout for the ID/EX stage.
// Bubble constant and the bypass hit rule live here so the stage and the forward muxes agree.
package id_ex_stage_pkg;
    localparam int XLEN = 32;
    localparam int AOPW = 4;
    localparam logic [XLEN-1:0] RST_PC = '0;

    typedef enum logic [1:0] {
        WD_ALU = 2'd0,
        WD_MEM = 2'd1,
        WD_PC4 = 2'd2,
        WD_IMM = 2'd3
    } wd_sel_e;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [4:0]      rR1;
        logic [4:0]      rR2;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [4:0]      wR;
        logic            rf_we;
        logic            mem_re;
        logic            mem_we;
        logic [AOPW-1:0] alu_op;
        wd_sel_e         wd_sel;
    } ex_reg_t;

    localparam ex_reg_t EX_BUBBLE = '{
        valid: 1'b0, pc: RST_PC, imm: '0, rR1: '0, rR2: '0, op1: '0, op2: '0,
        wR: '0, rf_we: 1'b0, mem_re: 1'b0, mem_we: 1'b0, alu_op: '0, wd_sel: WD_ALU
    };

    // x0 is hardwired, so a write "to" it never counts as a producer.
    function automatic logic reg_hit(input logic we, input logic [4:0] wR, input logic [4:0] rR);
        return we && (wR == rR) && (rR != 5'd0);
    endfunction
endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: decoded ID fields, MEM/WB result taps, redirect/hold controls and EX outputs.
// master = surrounding pipeline, slave = the ID/EX stage.
interface id_ex_stage_if;
    import id_ex_stage_pkg::*;

    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [4:0]      id_rR1;
    logic [4:0]      id_rR2;
    logic            id_rs1_used;
    logic            id_rs2_used;
    logic [XLEN-1:0] id_rD1;
    logic [XLEN-1:0] id_rD2;
    logic [XLEN-1:0] id_imm;
    logic [4:0]      id_wR;
    logic            id_rf_we;
    logic [AOPW-1:0] id_alu_op;
    logic            id_mem_re;
    logic            id_mem_we;
    logic [1:0]      id_wd_sel;

    logic            mem_we;
    logic [4:0]      mem_wR;
    logic [XLEN-1:0] mem_wD;
    logic            wb_we;
    logic [4:0]      wb_wR;
    logic [XLEN-1:0] wb_wD;

    logic            flush;
    logic            ex_hold;
    logic            stall_id;

    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_imm;
    logic [XLEN-1:0] ex_op1;
    logic [XLEN-1:0] ex_op2;
    logic [4:0]      ex_wR;
    logic            ex_rf_we;
    logic            ex_mem_re;
    logic            ex_mem_we;
    logic [AOPW-1:0] ex_alu_op;
    logic [1:0]      ex_wd_sel;

    modport master (
        output id_valid, id_pc, id_rR1, id_rR2, id_rs1_used, id_rs2_used, id_rD1, id_rD2,
               id_imm, id_wR, id_rf_we, id_alu_op, id_mem_re, id_mem_we, id_wd_sel,
               mem_we, mem_wR, mem_wD, wb_we, wb_wR, wb_wD, flush, ex_hold,
        input  stall_id, ex_valid, ex_pc, ex_imm, ex_op1, ex_op2, ex_wR, ex_rf_we,
               ex_mem_re, ex_mem_we, ex_alu_op, ex_wd_sel
    );

    modport slave (
        input  id_valid, id_pc, id_rR1, id_rR2, id_rs1_used, id_rs2_used, id_rD1, id_rD2,
               id_imm, id_wR, id_rf_we, id_alu_op, id_mem_re, id_mem_we, id_wd_sel,
               mem_we, mem_wR, mem_wD, wb_we, wb_wR, wb_wD, flush, ex_hold,
        output stall_id, ex_valid, ex_pc, ex_imm, ex_op1, ex_op2, ex_wR, ex_rf_we,
               ex_mem_re, ex_mem_we, ex_alu_op, ex_wd_sel
    );
endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand bypass for one EX source: MEM result beats WB result beats the latched value; x0 reads 0.
// Purely combinational, zero latency, no backpressure.
module id_ex_stage_fwd_mux
    import id_ex_stage_pkg::*;
(
    input  logic [4:0]      rR_i,
    input  logic [XLEN-1:0] lat_i,
    input  logic            mem_we_i,
    input  logic [4:0]      mem_wR_i,
    input  logic [XLEN-1:0] mem_wD_i,
    input  logic            wb_we_i,
    input  logic [4:0]      wb_wR_i,
    input  logic [XLEN-1:0] wb_wD_i,
    output logic [XLEN-1:0] op_o
);
    always_comb begin
        op_o = lat_i;
        if (rR_i == 5'd0) begin
            op_o = '0;
        end else if (reg_hit(mem_we_i, mem_wR_i, rR_i)) begin
            op_o = mem_wD_i;
        end else if (reg_hit(wb_we_i, wb_wR_i, rR_i)) begin
            op_o = wb_wD_i;
        end
    end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use stall; 1 cycle ID->EX.
// Backpressure: ex_hold freezes EX (operands keep refreshing) and raises stall_id; flush overrides both.
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave bus
);
    ex_reg_t         ex_q;
    ex_reg_t         ex_d;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            lu;

    id_ex_stage_fwd_mux u_fwd1 (
        .rR_i     (ex_q.rR1),
        .lat_i    (ex_q.op1),
        .mem_we_i (bus.mem_we),
        .mem_wR_i (bus.mem_wR),
        .mem_wD_i (bus.mem_wD),
        .wb_we_i  (bus.wb_we),
        .wb_wR_i  (bus.wb_wR),
        .wb_wD_i  (bus.wb_wD),
        .op_o     (op1)
    );

    id_ex_stage_fwd_mux u_fwd2 (
        .rR_i     (ex_q.rR2),
        .lat_i    (ex_q.op2),
        .mem_we_i (bus.mem_we),
        .mem_wR_i (bus.mem_wR),
        .mem_wD_i (bus.mem_wD),
        .wb_we_i  (bus.wb_we),
        .wb_wR_i  (bus.wb_wR),
        .wb_wD_i  (bus.wb_wD),
        .op_o     (op2)
    );

    assign lu = ex_q.valid & ex_q.mem_re & ex_q.rf_we & (ex_q.wR != 5'd0) & bus.id_valid &
                ((bus.id_rs1_used & (bus.id_rR1 == ex_q.wR)) |
                 (bus.id_rs2_used & (bus.id_rR2 == ex_q.wR)));

    // rst_n gates the stall so ID is released the instant reset asserts, clock or not.
    assign bus.stall_id = rst_n & (lu | bus.ex_hold) & ~bus.flush;

    always_comb begin
        ex_d = ex_q;
        if (bus.flush) begin
            ex_d = EX_BUBBLE;
        end else if (bus.ex_hold) begin
            ex_d.op1 = op1;
            ex_d.op2 = op2;
        end else if (lu) begin
            ex_d = EX_BUBBLE;
        end else begin
            ex_d.valid  = bus.id_valid;
            ex_d.pc     = bus.id_pc;
            ex_d.imm    = bus.id_imm;
            ex_d.rR1    = bus.id_rR1;
            ex_d.rR2    = bus.id_rR2;
            ex_d.wR     = bus.id_wR;
            ex_d.rf_we  = bus.id_valid & bus.id_rf_we;
            ex_d.mem_re = bus.id_valid & bus.id_mem_re;
            ex_d.mem_we = bus.id_valid & bus.id_mem_we;
            ex_d.alu_op = bus.id_alu_op;
            ex_d.wd_sel = wd_sel_e'(bus.id_wd_sel);
            // The rf write on this same edge is not yet visible in rD, so take it from WB directly.
            ex_d.op1    = reg_hit(bus.wb_we, bus.wb_wR, bus.id_rR1) ? bus.wb_wD : bus.id_rD1;
            ex_d.op2    = reg_hit(bus.wb_we, bus.wb_wR, bus.id_rR2) ? bus.wb_wD : bus.id_rD2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= EX_BUBBLE;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign bus.ex_valid  = ex_q.valid;
    assign bus.ex_pc     = ex_q.pc;
    assign bus.ex_imm    = ex_q.imm;
    assign bus.ex_op1    = op1;
    assign bus.ex_op2    = op2;
    assign bus.ex_wR     = ex_q.wR;
    assign bus.ex_rf_we  = ex_q.rf_we;
    assign bus.ex_mem_re = ex_q.mem_re;
    assign bus.ex_mem_we = ex_q.mem_we;
    assign bus.ex_alu_op = ex_q.alu_op;
    assign bus.ex_wd_sel = ex_q.wd_sel;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard scenarios then randomized traffic against a rule-level model.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    id_ex_stage_if bus ();
    id_ex_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Expected architectural contents of EX.
    logic        m_valid, m_rfwe, m_mre, m_mwe;
    logic [31:0] m_pc, m_imm, m_v1, m_v2;
    logic [4:0]  m_r1, m_r2, m_wR;
    logic [3:0]  m_aop;
    logic [1:0]  m_wds;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_bubble();
        m_valid = 0; m_rfwe = 0; m_mre = 0; m_mwe = 0;
        m_pc = 0; m_imm = 0; m_v1 = 0; m_v2 = 0;
        m_r1 = 0; m_r2 = 0; m_wR = 0; m_aop = 0; m_wds = 0;
    endtask

    // Newest value of register r visible to EX right now.
    function automatic logic [31:0] freshest(input logic [4:0] r, input logic [31:0] held);
        if (r == 5'd0) return 32'h0;
        if (bus.mem_we && bus.mem_wR == r) return bus.mem_wD;
        if (bus.wb_we && bus.wb_wR == r) return bus.wb_wD;
        return held;
    endfunction

    function automatic logic load_use();
        return m_valid && m_mre && m_rfwe && m_wR != 0 && bus.id_valid &&
               ((bus.id_rs1_used && bus.id_rR1 == m_wR) || (bus.id_rs2_used && bus.id_rR2 == m_wR));
    endfunction

    function automatic logic [31:0] rf_read(input logic [4:0] r, input logic [31:0] rd);
        if (bus.wb_we && bus.wb_wR == r && r != 0) return bus.wb_wD;
        return rd;
    endfunction

    task automatic idle();
        bus.id_valid = 0; bus.id_pc = 0; bus.id_rR1 = 0; bus.id_rR2 = 0;
        bus.id_rs1_used = 0; bus.id_rs2_used = 0; bus.id_rD1 = 0; bus.id_rD2 = 0;
        bus.id_imm = 0; bus.id_wR = 0; bus.id_rf_we = 0; bus.id_alu_op = 0;
        bus.id_mem_re = 0; bus.id_mem_we = 0; bus.id_wd_sel = 0;
        bus.mem_we = 0; bus.mem_wR = 0; bus.mem_wD = 0;
        bus.wb_we = 0; bus.wb_wR = 0; bus.wb_wD = 0;
        bus.flush = 0; bus.ex_hold = 0;
    endtask

    task automatic randomize_inputs();
        bus.id_valid    = ($urandom_range(0, 5) != 0);
        bus.id_pc       = $urandom;
        bus.id_rR1      = 5'($urandom_range(0, 7));
        bus.id_rR2      = 5'($urandom_range(0, 7));
        bus.id_rs1_used = $urandom_range(0, 3) != 0;
        bus.id_rs2_used = $urandom_range(0, 1) != 0;
        bus.id_rD1      = $urandom;
        bus.id_rD2      = $urandom;
        bus.id_imm      = $urandom;
        bus.id_wR       = 5'($urandom_range(0, 7));
        bus.id_rf_we    = $urandom_range(0, 3) != 0;
        bus.id_alu_op   = 4'($urandom);
        bus.id_mem_re   = $urandom_range(0, 2) == 0;
        bus.id_mem_we   = !bus.id_mem_re && ($urandom_range(0, 4) == 0);
        bus.id_wd_sel   = 2'($urandom);
        bus.mem_we      = $urandom_range(0, 1) != 0;
        bus.mem_wR      = 5'($urandom_range(0, 7));
        bus.mem_wD      = $urandom;
        bus.wb_we       = $urandom_range(0, 1) != 0;
        bus.wb_wR       = 5'($urandom_range(0, 7));
        bus.wb_wD       = $urandom;
        bus.flush       = $urandom_range(0, 11) == 0;
        bus.ex_hold     = $urandom_range(0, 5) == 0;
    endtask

    // Compare everything at the negedge, advance the model, then step past the next posedge.
    task automatic cycle();
        logic lu;
        @(negedge clk);
        lu = load_use();
        chk("stall_id", 32'(bus.stall_id), 32'((lu || bus.ex_hold) && !bus.flush));
        chk("ex_valid", 32'(bus.ex_valid), 32'(m_valid));
        chk("ex_pc", bus.ex_pc, m_pc);
        chk("ex_imm", bus.ex_imm, m_imm);
        chk("ex_op1", bus.ex_op1, freshest(m_r1, m_v1));
        chk("ex_op2", bus.ex_op2, freshest(m_r2, m_v2));
        chk("ex_wR", 32'(bus.ex_wR), 32'(m_wR));
        chk("ex_rf_we", 32'(bus.ex_rf_we), 32'(m_rfwe));
        chk("ex_mem_re", 32'(bus.ex_mem_re), 32'(m_mre));
        chk("ex_mem_we", 32'(bus.ex_mem_we), 32'(m_mwe));
        chk("ex_alu_op", 32'(bus.ex_alu_op), 32'(m_aop));
        chk("ex_wd_sel", 32'(bus.ex_wd_sel), 32'(m_wds));
        if (bus.flush) begin
            model_bubble();
        end else if (bus.ex_hold) begin
            m_v1 = freshest(m_r1, m_v1);
            m_v2 = freshest(m_r2, m_v2);
        end else if (lu) begin
            model_bubble();
        end else begin
            m_valid = bus.id_valid;
            m_pc = bus.id_pc; m_imm = bus.id_imm;
            m_r1 = bus.id_rR1; m_r2 = bus.id_rR2; m_wR = bus.id_wR;
            m_rfwe = bus.id_valid && bus.id_rf_we;
            m_mre = bus.id_valid && bus.id_mem_re;
            m_mwe = bus.id_valid && bus.id_mem_we;
            m_aop = bus.id_alu_op; m_wds = bus.id_wd_sel;
            m_v1 = rf_read(bus.id_rR1, bus.id_rD1);
            m_v2 = rf_read(bus.id_rR2, bus.id_rD2);
        end
        @(posedge clk);
        #1;
    endtask

    // Async reset between edges: outputs must clear without any clock.
    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_ex_valid", 32'(bus.ex_valid), 32'h0);
        chk("rst_ex_rf_we", 32'(bus.ex_rf_we), 32'h0);
        chk("rst_stall_id", 32'(bus.stall_id), 32'h0);
        chk("rst_ex_pc", bus.ex_pc, 32'h0);
        model_bubble();
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        model_bubble();
        repeat (2) @(posedge clk);
        #1;
        chk("init_ex_valid", 32'(bus.ex_valid), 32'h0);
        chk("init_stall_id", 32'(bus.stall_id), 32'h0);
        rst_n = 1'b1;

        // EX->MEM forward: add x5 ; sub x6,x5,x1
        idle();
        bus.id_valid = 1; bus.id_wR = 5; bus.id_rf_we = 1; bus.id_pc = 32'h100;
        cycle();
        idle();
        bus.id_valid = 1; bus.id_rR1 = 5; bus.id_rR2 = 1; bus.id_rs1_used = 1; bus.id_rs2_used = 1;
        bus.id_rD1 = 32'hDEAD; bus.id_rD2 = 32'h1; bus.id_wR = 6; bus.id_rf_we = 1; bus.id_pc = 32'h104;
        #1;
        chk("t2_no_stall", 32'(bus.stall_id), 32'h0);
        cycle();
        idle();
        bus.mem_we = 1; bus.mem_wR = 5; bus.mem_wD = 32'h10;
        #1;
        chk("t2_op1_mem", bus.ex_op1, 32'h10);
        chk("t2_pc", bus.ex_pc, 32'h104);
        cycle();

        // Capture bypass from the WB write landing on the same edge
        idle();
        bus.wb_we = 1; bus.wb_wR = 3; bus.wb_wD = 32'hAB;
        bus.id_valid = 1; bus.id_rR2 = 3; bus.id_rs2_used = 1; bus.id_rD2 = 32'h0;
        cycle();
        idle();
        #1;
        chk("t3_op2_byp", bus.ex_op2, 32'hAB);
        cycle();

        // Load-use: lw x7 followed by a reader of x7
        idle();
        bus.id_valid = 1; bus.id_mem_re = 1; bus.id_rf_we = 1; bus.id_wR = 7; bus.id_wd_sel = 2'd1;
        cycle();
        idle();
        bus.id_valid = 1; bus.id_rR1 = 7; bus.id_rs1_used = 1; bus.id_rD1 = 32'h5; bus.id_pc = 32'h200;
        #1;
        chk("t4_stall", 32'(bus.stall_id), 32'h1);
        cycle();
        bus.mem_we = 1; bus.mem_wR = 7; bus.mem_wD = 32'h77;
        #1;
        chk("t4_bubble", 32'(bus.ex_valid), 32'h0);
        chk("t4_stall_once", 32'(bus.stall_id), 32'h0);
        cycle();
        idle();
        bus.wb_we = 1; bus.wb_wR = 7; bus.wb_wD = 32'h77;
        #1;
        chk("t4_valid", 32'(bus.ex_valid), 32'h1);
        chk("t4_op1", bus.ex_op1, 32'h77);
        cycle();

        // flush beats ex_hold and load-use together
        idle();
        bus.id_valid = 1; bus.id_mem_re = 1; bus.id_rf_we = 1; bus.id_wR = 9;
        cycle();
        idle();
        bus.id_valid = 1; bus.id_rR2 = 9; bus.id_rs2_used = 1;
        bus.ex_hold = 1; bus.flush = 1;
        #1;
        chk("t5_stall", 32'(bus.stall_id), 32'h0);
        cycle();
        idle();
        #1;
        chk("t5_valid", 32'(bus.ex_valid), 32'h0);
        chk("t5_rf_we", 32'(bus.ex_rf_we), 32'h0);
        cycle();

        // x0 never forwarded; hold keeps a value that retires mid-hold
        idle();
        bus.id_valid = 1; bus.id_rR1 = 0; bus.id_rD1 = 32'h55; bus.id_rR2 = 4; bus.id_rD2 = 32'h11;
        bus.id_rs1_used = 1; bus.id_rs2_used = 1;
        cycle();
        idle();
        bus.mem_we = 1; bus.mem_wR = 0; bus.mem_wD = 32'hFF;
        bus.wb_we = 1; bus.wb_wR = 4; bus.wb_wD = 32'h44; bus.ex_hold = 1;
        #1;
        chk("t6_x0", bus.ex_op1, 32'h0);
        chk("t6_hold0", bus.ex_op2, 32'h44);
        cycle();
        for (int i = 1; i < 3; i++) begin
            idle();
            bus.ex_hold = 1;
            #1;
            chk($sformatf("t6_hold%0d", i), bus.ex_op2, 32'h44);
            cycle();
        end
        idle();
        #1;
        chk("t6_after_hold", bus.ex_op2, 32'h44);
        cycle();

        // Mid-stall reset, then randomized traffic with occasional resets
        idle();
        bus.ex_hold = 1;
        #1;
        chk("t1_stall_pre", 32'(bus.stall_id), 32'h1);
        pulse_reset();
        for (int i = 0; i < 3000; i++) begin
            randomize_inputs();
            if ($urandom_range(0, 249) == 0) begin
                pulse_reset();
                randomize_inputs();
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
